// File: rtl/mips_imem_loader.sv
// Boot loader for the MIPS instruction memory: receives a framed byte stream
// (length, big-endian words, XOR checksum) and keeps the core in reset until it verifies.
module mips_imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  GlobalClock,
    input  logic                  GlobalReset,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    input  logic                  Restart,
    output logic                  ImemWe,
    output logic [ADDR_WIDTH-1:0] ImemAddr,
    output logic [31:0]           ImemWdata,
    output logic                  CoreHold,
    output logic                  LoadDone,
    output logic                  LoadError
);

    typedef enum logic [2:0] {LEN_H, LEN_L, DATA, CHECK, DONE, ERR} state_t;

    localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

    state_t      state, nxt;
    logic        rdy_en;
    logic        accept;
    logic [15:0] len;
    logic [15:0] len_new;
    logic [15:0] wcnt;
    logic [1:0]  bcnt;
    logic [23:0] word;
    logic [7:0]  csum;
    logic        last_byte;

    assign len_new   = {len[15:8], ByteIn};
    assign last_byte = (bcnt == 2'd3) && (wcnt + 16'd1 == len);

    always_ff @(posedge GlobalClock or negedge GlobalReset) begin
        if (!GlobalReset) state <= LEN_H;
        else              state <= nxt;
    end

    always_comb begin
        nxt       = state;
        ByteReady = rdy_en && !Restart &&
                    (state == LEN_H || state == LEN_L || state == DATA || state == CHECK);
        accept    = ByteReady && ByteValid;
        if (Restart) begin
            nxt = LEN_H;
        end else if (accept) begin
            case (state)
                LEN_H: nxt = LEN_L;
                LEN_L: begin
                    if ({1'b0, len_new} > CAP) nxt = ERR;
                    else if (len_new == 16'd0) nxt = CHECK;
                    else                       nxt = DATA;
                end
                DATA:  if (last_byte) nxt = CHECK;
                CHECK: nxt = (ByteIn == csum) ? DONE : ERR;
                default: nxt = state;
            endcase
        end
    end

    assign CoreHold  = (state != DONE);
    assign LoadDone  = (state == DONE);
    assign LoadError = (state == ERR);

    always_ff @(posedge GlobalClock or negedge GlobalReset) begin
        if (!GlobalReset) begin
            rdy_en    <= 1'b0;
            len       <= '0;
            wcnt      <= '0;
            bcnt      <= '0;
            word      <= '0;
            csum      <= '0;
            ImemWe    <= 1'b0;
            ImemAddr  <= '0;
            ImemWdata <= '0;
        end else begin
            rdy_en <= 1'b1;
            ImemWe <= 1'b0;
            if (Restart) begin
                len  <= '0;
                wcnt <= '0;
                bcnt <= '0;
                csum <= '0;
            end else if (accept) begin
                case (state)
                    LEN_H: begin
                        len  <= {ByteIn, 8'h00};
                        csum <= ByteIn;
                    end
                    LEN_L: begin
                        len  <= len_new;
                        csum <= csum ^ ByteIn;
                    end
                    DATA: begin
                        csum <= csum ^ ByteIn;
                        word <= {word[15:0], ByteIn};
                        bcnt <= bcnt + 2'd1;
                        // Fourth byte completes the word; the write lands next cycle.
                        if (bcnt == 2'd3) begin
                            ImemWe    <= 1'b1;
                            ImemAddr  <= wcnt[ADDR_WIDTH-1:0];
                            ImemWdata <= {word, ByteIn};
                            wcnt      <= wcnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_imem_loader.sv
// Directed bench for mips_imem_loader: frames with hand-computed checksums,
// write log collected on the falling edge and compared against expected words.
module tb_mips_imem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          restart = 1'b0;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          hold, done, err;

    int ncmp = 0;
    int nfail = 0;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    logic [7:0]    fr[$];
    logic [31:0]   ew[$];

    mips_imem_loader #(.ADDR_WIDTH(AW)) dut (
        .GlobalClock(clk),
        .GlobalReset(rst_n),
        .ByteIn(byte_in),
        .ByteValid(byte_valid),
        .ByteReady(byte_ready),
        .Restart(restart),
        .ImemWe(we),
        .ImemAddr(addr),
        .ImemWdata(wdata),
        .CoreHold(hold),
        .LoadDone(done),
        .LoadError(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            wa_q.push_back(addr);
            wd_q.push_back(wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_seq(input logic [7:0] q[$], input int maxgap);
        foreach (q[i]) begin
            int t = 0;
            int g;
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (g) begin
                byte_in    = 8'($urandom);
                byte_valid = 1'b0;
                @(negedge clk);
            end
            while (!byte_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!byte_ready) chk("ready_timeout", {31'd0, byte_ready}, 32'd1);
            byte_in    = q[i];
            byte_valid = 1'b1;
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic do_restart();
        restart    = 1'b1;
        byte_in    = 8'h5A;
        byte_valid = 1'b1;
        #1;
        chk("ready_in_restart", {31'd0, byte_ready}, 32'd0);
        @(negedge clk);
        restart    = 1'b0;
        byte_valid = 1'b0;
        chk("hold_after_restart", {31'd0, hold}, 32'd1);
        chk("flags_after_restart", {30'd0, done, err}, 32'd0);
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic check_log(input string tag, input logic [31:0] exp[$]);
        chk({tag, "_count"}, wd_q.size(), exp.size());
        foreach (exp[i]) begin
            if (i < wd_q.size()) begin
                chk({tag, "_addr"}, {24'd0, wa_q[i]}, i);
                chk({tag, "_data"}, wd_q[i], exp[i]);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_we",    {31'd0, we},         32'd0);
        chk("rst_addr",  {24'd0, addr},       32'd0);
        chk("rst_wdata", wdata,               32'd0);
        chk("rst_flags", {29'd0, hold, done, err}, 32'b100);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, byte_ready}, 32'd1);

        // N=2 good frame, checksum 0xAA
        fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
        send_seq(fr, 0);
        chk("t1_we0",   {31'd0, we}, 32'd1);
        chk("t1_addr0", {24'd0, addr}, 32'd0);
        chk("t1_data0", wdata, 32'h20080005);
        fr = '{8'h8C, 8'h09, 8'h00, 8'h00};
        send_seq(fr, 0);
        chk("t1_we1",   {31'd0, we}, 32'd1);
        chk("t1_addr1", {24'd0, addr}, 32'd1);
        chk("t1_data1", wdata, 32'h8C090000);
        chk("t1_hold_pre", {31'd0, hold}, 32'd1);
        fr = '{8'hAA};
        send_seq(fr, 0);
        chk("t1_done",  {31'd0, done}, 32'd1);
        chk("t1_hold",  {31'd0, hold}, 32'd0);
        chk("t1_err",   {31'd0, err},  32'd0);
        chk("t1_ready", {31'd0, byte_ready}, 32'd0);
        ew = '{32'h20080005, 32'h8C090000};
        check_log("t1", ew);
        do_restart();

        // Same frame, CHK bit 0 flipped
        fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00, 8'hAB};
        send_seq(fr, 0);
        chk("t2_err",   {31'd0, err},  32'd1);
        chk("t2_hold",  {31'd0, hold}, 32'd1);
        chk("t2_done",  {31'd0, done}, 32'd0);
        chk("t2_ready", {31'd0, byte_ready}, 32'd0);
        check_log("t2", ew);
        do_restart();

        // Oversize length 257
        fr = '{8'h01};
        send_seq(fr, 0);
        chk("t3_err_early", {31'd0, err}, 32'd0);
        fr = '{8'h01};
        send_seq(fr, 0);
        chk("t3_err",   {31'd0, err}, 32'd1);
        chk("t3_ready", {31'd0, byte_ready}, 32'd0);
        repeat (3) @(negedge clk);
        ew = '{};
        check_log("t3", ew);
        do_restart();

        // N=0 good, then N=0 bad
        fr = '{8'h00, 8'h00, 8'h00};
        send_seq(fr, 0);
        chk("t4_done", {31'd0, done}, 32'd1);
        check_log("t4", ew);
        do_restart();
        fr = '{8'h00, 8'h00, 8'h01};
        send_seq(fr, 0);
        chk("t4b_err", {31'd0, err}, 32'd1);
        chk("t4b_done", {31'd0, done}, 32'd0);
        do_restart();

        // N=3 with random valid gaps, checksum 0xCF
        fr = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCF};
        send_seq(fr, 3);
        chk("t5_done", {31'd0, done}, 32'd1);
        ew = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        check_log("t5", ew);
        do_restart();

        // Restart mid-DATA, then N=1 0xDEADBEEF (checksum 0x23)
        fr = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_seq(fr, 0);
        do_restart();
        fr = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
        send_seq(fr, 0);
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_hold", {31'd0, hold}, 32'd0);
        ew = '{32'hDEADBEEF};
        check_log("t6", ew);
        do_restart();

        // Asynchronous reset in the middle of DATA
        fr = '{8'h00, 8'h02, 8'h11, 8'h22};
        send_seq(fr, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ready", {31'd0, byte_ready}, 32'd0);
        chk("ar_we",    {31'd0, we},         32'd0);
        chk("ar_addr",  {24'd0, addr},       32'd0);
        chk("ar_wdata", wdata,               32'd0);
        chk("ar_flags", {29'd0, hold, done, err}, 32'b100);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_ready_after", {31'd0, byte_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
